// File: rtl/bert_pkg.sv
// Shared definitions for the BERT measurement sequencer: state encoding and fixed timing constants.
package bert_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned CLEAR_CYCLES = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_COUNT = 3'd4,
        ST_SNAP  = 3'd5,
        ST_DONE  = 3'd6
    } bert_state_e;

    function automatic logic is_busy(bert_state_e s);
        return (s inside {ST_CLEAR, ST_SEED, ST_FLUSH, ST_COUNT, ST_SNAP});
    endfunction

endpackage

// File: rtl/bert_seq_timer.sv
// Loadable down-counter that stops at zero; shared by the CLEAR, SEED-timeout and FLUSH phases.
module bert_seq_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    output logic             o_zero_c
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero_c = (count_q == '0);

endmodule

// File: rtl/bert_sequencer.sv
// Sequences a BERT measurement: clear, seed lock, pipeline flush, count, snapshot results.
// Optional error-limit stop when BERT_SEQ_ERR_LIMIT_EN is defined.
module bert_sequencer
    import bert_pkg::*;
#(
    parameter int unsigned SeedTimeoutWidth = 16,
    parameter int unsigned SettleCycles     = 8,
    parameter int unsigned FlushCycles      = 3,
    parameter int unsigned CountWidth       = 41
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [SeedTimeoutWidth-1:0] i_cfg_seed_timeout,
`ifdef BERT_SEQ_ERR_LIMIT_EN
    input  logic [CountWidth-1:0]       i_cfg_err_limit,
`endif
    input  logic                        i_prbs_seed_good,
    input  logic                        i_ber_shutoff,
    input  logic [CountWidth-1:0]       i_ber_count,
    input  logic [CountWidth-1:0]       i_bit_count,
    output logic                        o_bert_rst,
    output logic                        o_prbs_en,
    output logic                        o_prbs_seed_en,
    output logic                        o_prbs_run_en,
    output logic                        o_ber_count_en,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_fail,
    output logic [STATE_W-1:0]          o_state,
    output logic [CountWidth-1:0]       o_err_snap,
    output logic [CountWidth-1:0]       o_bits_snap
);

    localparam int unsigned TimerWidth = SeedTimeoutWidth;
    localparam int unsigned SeedCntW   = $clog2(SettleCycles + 1);

    bert_state_e           state_q, state_d;
    logic [SeedCntW-1:0]   seed_cnt_q, seed_cnt_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic [CountWidth-1:0] err_snap_q, err_snap_d;
    logic [CountWidth-1:0] bits_snap_q, bits_snap_d;
    logic                  bert_rst_q, prbs_en_q, seed_en_q, run_en_q, count_en_q, busy_q;

    logic                  timer_load_c;
    logic [TimerWidth-1:0] timer_val_c;
    logic                  timer_zero_c;
    logic                  lock_c;
    logic                  timeout_c;
    logic                  err_limit_hit_c;

    bert_seq_timer #(.Width(TimerWidth)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (timer_load_c),
        .i_load_val (timer_val_c),
        .o_zero_c   (timer_zero_c)
    );

`ifdef BERT_SEQ_ERR_LIMIT_EN
    assign err_limit_hit_c = (i_cfg_err_limit != '0) && (i_ber_count >= i_cfg_err_limit);
`else
    assign err_limit_hit_c = 1'b0;
`endif

    // Lock fires on the cycle the consecutive-good count reaches SettleCycles.
    assign lock_c    = i_prbs_seed_good && (seed_cnt_q == SeedCntW'(SettleCycles - 1));
    assign timeout_c = (i_cfg_seed_timeout != '0) && timer_zero_c;

    always_comb begin
        state_d      = state_q;
        seed_cnt_d   = seed_cnt_q;
        done_d       = done_q;
        fail_d       = fail_q;
        err_snap_d   = err_snap_q;
        bits_snap_d  = bits_snap_q;
        timer_load_c = 1'b0;
        timer_val_c  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d      = ST_CLEAR;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                    timer_load_c = 1'b1;
                    timer_val_c  = TimerWidth'(CLEAR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    state_d = ST_DONE;
                    fail_d  = 1'b1;
                end else if (timer_zero_c) begin
                    state_d      = ST_SEED;
                    seed_cnt_d   = '0;
                    timer_load_c = 1'b1;
                    timer_val_c  = i_cfg_seed_timeout - TimerWidth'(1);
                end
            end
            ST_SEED: begin
                if (!i_prbs_seed_good) begin
                    seed_cnt_d = '0;
                end else if (seed_cnt_q != SeedCntW'(SettleCycles)) begin
                    seed_cnt_d = seed_cnt_q + SeedCntW'(1);
                end
                if (i_abort) begin
                    state_d = ST_DONE;
                    fail_d  = 1'b1;
                end else if (lock_c) begin
                    state_d      = ST_FLUSH;
                    timer_load_c = 1'b1;
                    timer_val_c  = TimerWidth'(FlushCycles - 1);
                end else if (timeout_c) begin
                    state_d = ST_DONE;
                    fail_d  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (i_abort) begin
                    state_d = ST_DONE;
                    fail_d  = 1'b1;
                end else if (timer_zero_c) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (i_abort || i_ber_shutoff || err_limit_hit_c) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                state_d     = ST_DONE;
                err_snap_d  = i_ber_count;
                bits_snap_d = i_bit_count;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d = 1'b1;
        end
    end

    // Control outputs are decoded from the next state so they track the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            seed_cnt_q  <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            err_snap_q  <= '0;
            bits_snap_q <= '0;
            bert_rst_q  <= 1'b0;
            prbs_en_q   <= 1'b0;
            seed_en_q   <= 1'b0;
            run_en_q    <= 1'b0;
            count_en_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            err_snap_q  <= err_snap_d;
            bits_snap_q <= bits_snap_d;
            bert_rst_q  <= (state_d == ST_CLEAR);
            prbs_en_q   <= (state_d inside {ST_SEED, ST_FLUSH, ST_COUNT});
            seed_en_q   <= (state_d == ST_SEED);
            run_en_q    <= (state_d inside {ST_FLUSH, ST_COUNT});
            count_en_q  <= (state_d == ST_COUNT);
            busy_q      <= is_busy(state_d);
        end
    end

    assign o_state        = state_q;
    assign o_bert_rst     = bert_rst_q;
    assign o_prbs_en      = prbs_en_q;
    assign o_prbs_seed_en = seed_en_q;
    assign o_prbs_run_en  = run_en_q;
    assign o_ber_count_en = count_en_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_fail         = fail_q;
    assign o_err_snap     = err_snap_q;
    assign o_bits_snap    = bits_snap_q;

endmodule

// File: tb/tb_bert_sequencer.sv
// Directed self-checking bench for bert_sequencer with immediate assertions at each check point.
module tb_bert_sequencer;

    localparam int unsigned CW = 41;
    localparam int unsigned TW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [TW-1:0] seed_timeout;
`ifdef BERT_SEQ_ERR_LIMIT_EN
    logic [CW-1:0] err_limit;
`endif
    logic          seed_good;
    logic          shutoff;
    logic [CW-1:0] ber_count;
    logic [CW-1:0] bit_count;
    logic          bert_rst, prbs_en, seed_en, run_en, count_en, busy, done, fail;
    logic [2:0]    state;
    logic [CW-1:0] err_snap, bits_snap;

    int n_checks = 0;
    int n_fail   = 0;

    bert_sequencer dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_abort            (abort),
        .i_cfg_seed_timeout (seed_timeout),
`ifdef BERT_SEQ_ERR_LIMIT_EN
        .i_cfg_err_limit    (err_limit),
`endif
        .i_prbs_seed_good   (seed_good),
        .i_ber_shutoff      (shutoff),
        .i_ber_count        (ber_count),
        .i_bit_count        (bit_count),
        .o_bert_rst         (bert_rst),
        .o_prbs_en          (prbs_en),
        .o_prbs_seed_en     (seed_en),
        .o_prbs_run_en      (run_en),
        .o_ber_count_en     (count_en),
        .o_busy             (busy),
        .o_done             (done),
        .o_fail             (fail),
        .o_state            (state),
        .o_err_snap         (err_snap),
        .o_bits_snap        (bits_snap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step until the state leaves the given value, returning the number of cycles spent there.
    task automatic cycles_in(input logic [2:0] st, output int n);
        n = 0;
        while (state == st && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st);
        int n;
        n = 0;
        while (state != st && n < 200) begin
            n++;
            tick();
        end
        chk(tag, 64'(state), 64'(st));
    endtask

    initial begin
        int  n;
        logic cnt_seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; seed_timeout = '0;
        seed_good = 1'b0; shutoff = 1'b0; ber_count = '0; bit_count = '0;
`ifdef BERT_SEQ_ERR_LIMIT_EN
        err_limit = '0;
`endif
        tick(); tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fail", 64'(fail), 64'd0);
        chk("rst_prbs_en", 64'(prbs_en), 64'd0);
        chk("rst_err_snap", 64'(err_snap), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_hold", 64'(state), 64'd0);

        // Reset while counting, and start ignored in COUNT.
        seed_good = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_clear", 64'(state), 64'd1);
        wait_state("reach_count_a", 3'd4);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_ignored_count", 64'(state), 64'd4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_count_state", 64'(state), 64'd0);
        chk("rst_count_en", 64'(count_en), 64'd0);
        chk("rst_count_prbs", 64'(prbs_en), 64'd0);
        chk("rst_count_busy", 64'(busy), 64'd0);

        // Nominal measurement.
        start = 1'b1; tick(); start = 1'b0;
        chk("clr1_state", 64'(state), 64'd1);
        chk("clr1_bert_rst", 64'(bert_rst), 64'd1);
        chk("clr1_busy", 64'(busy), 64'd1);
        tick();
        chk("clr2_bert_rst", 64'(bert_rst), 64'd1);
        tick();
        chk("seed_entry", 64'(state), 64'd2);
        chk("seed_bert_rst", 64'(bert_rst), 64'd0);
        chk("seed_prbs_en", 64'(prbs_en), 64'd1);
        cycles_in(3'd2, n);
        chk("seed_cycles", 64'(n), 64'd8);
        chk("flush_state", 64'(state), 64'd3);
        chk("flush_seed_en", 64'(seed_en), 64'd0);
        chk("flush_run_en", 64'(run_en), 64'd1);
        chk("flush_count_en", 64'(count_en), 64'd0);
        cycles_in(3'd3, n);
        chk("flush_cycles", 64'(n), 64'd3);
        chk("count_state", 64'(state), 64'd4);
        chk("count_en", 64'(count_en), 64'd1);
        chk("count_run_en", 64'(run_en), 64'd1);
        ber_count = 41'd7; bit_count = 41'd1024; shutoff = 1'b1;
        tick(); shutoff = 1'b0;
        chk("snap_state", 64'(state), 64'd5);
        chk("snap_count_en", 64'(count_en), 64'd0);
        chk("snap_busy", 64'(busy), 64'd1);
        tick();
        chk("done_state", 64'(state), 64'd6);
        chk("done_flag", 64'(done), 64'd1);
        chk("done_fail", 64'(fail), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_err_snap", 64'(err_snap), 64'd7);
        chk("done_bits_snap", 64'(bits_snap), 64'd1024);
        ber_count = 41'd99; bit_count = 41'd5000;
        tick();
        chk("idle_after_done", 64'(state), 64'd0);
        chk("done_hold", 64'(done), 64'd1);
        tick();
        chk("err_snap_hold", 64'(err_snap), 64'd7);
        chk("bits_snap_hold", 64'(bits_snap), 64'd1024);

        // Seed timeout of 20 cycles with seed_good stuck low.
        seed_good = 1'b0; seed_timeout = 16'd20;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_clears_done", 64'(done), 64'd0);
        tick(); tick();
        n = 0; cnt_seen = 1'b0;
        while (seed_en && n < 200) begin
            n++;
            if (count_en) cnt_seen = 1'b1;
            tick();
        end
        chk("timeout_seed_cycles", 64'(n), 64'd20);
        chk("timeout_state", 64'(state), 64'd6);
        chk("timeout_done", 64'(done), 64'd1);
        chk("timeout_fail", 64'(fail), 64'd1);
        chk("timeout_no_count", 64'(cnt_seen | count_en), 64'd0);
        chk("timeout_snap_kept", 64'(err_snap), 64'd7);
        tick();

        // Toggling seed_good never locks; a stable run of 8 does.
        seed_timeout = '0;
        start = 1'b1; tick(); start = 1'b0;
        chk("toggle_fail_cleared", 64'(fail), 64'd0);
        wait_state("toggle_seed", 3'd2);
        for (int i = 0; i < 40; i++) begin
            seed_good = (((i / 5) % 2) == 0);
            tick();
        end
        chk("toggle_no_lock", 64'(state), 64'd2);
        seed_good = 1'b1;
        n = 0;
        while (state == 3'd2 && n < 200) begin
            n++;
            tick();
        end
        chk("stable_lock_cycles", 64'(n), 64'd8);
        chk("stable_flush", 64'(state), 64'd3);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_flush_state", 64'(state), 64'd6);
        chk("abort_flush_fail", 64'(fail), 64'd1);
        chk("abort_flush_done", 64'(done), 64'd1);
        chk("abort_flush_snap", 64'(bits_snap), 64'd1024);
        tick();

        // Lock and timeout coincide: lock wins; then abort in COUNT snapshots normally.
        seed_timeout = 16'd8;
        start = 1'b1; tick(); start = 1'b0;
        wait_state("tie_seed", 3'd2);
        cycles_in(3'd2, n);
        chk("tie_seed_cycles", 64'(n), 64'd8);
        chk("tie_lock_wins", 64'(state), 64'd3);
        chk("tie_no_fail", 64'(fail), 64'd0);
        wait_state("tie_count", 3'd4);
        ber_count = 41'd3; bit_count = 41'd50;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_count_snap_state", 64'(state), 64'd5);
        tick();
        chk("abort_count_err_snap", 64'(err_snap), 64'd3);
        chk("abort_count_bits_snap", 64'(bits_snap), 64'd50);
        chk("abort_count_fail", 64'(fail), 64'd0);
        tick();

`ifdef BERT_SEQ_ERR_LIMIT_EN
        // Error limit stops counting once ber_count reaches it.
        seed_timeout = '0; err_limit = 41'd5; ber_count = 41'd0; bit_count = 41'd77;
        start = 1'b1; tick(); start = 1'b0;
        wait_state("lim_count", 3'd4);
        ber_count = 41'd4; tick();
        chk("lim_below", 64'(state), 64'd4);
        ber_count = 41'd5; tick();
        chk("lim_snap", 64'(state), 64'd5);
        tick();
        chk("lim_err_snap", 64'(err_snap), 64'd5);
        chk("lim_done", 64'(done), 64'd1);
        err_limit = '0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bert_sequencer.md
BERT_SEQUENCER -- requirements
Module: bert_sequencer

Interface
REQ-001 SHALL have parameter SeedTimeoutWidth, default 16: width of the seed-timeout counter.
REQ-002 SHALL have parameter SettleCycles, default 8: consecutive i_prbs_seed_good cycles needed to declare lock.
REQ-003 SHALL have parameter FlushCycles, default 3: RUN cycles before counting starts; covers the BERT datapath delay.
REQ-004 SHALL have parameter CountWidth, default 41: width of the BER and bit counters.
REQ-005 SHALL have port i_clk, input, 1: sole clock; one clock domain.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port i_start, input, 1: one-cycle request to start a measurement.
REQ-008 SHALL have port i_abort, input, 1: stop the measurement and go to SNAP.
REQ-009 SHALL have port i_cfg_seed_timeout, input, SeedTimeoutWidth: maximum SEED cycles; 0 means no timeout.
REQ-010 SHALL have port i_prbs_seed_good, input, 1: seed-good flag from the BERT.
REQ-011 SHALL have port i_ber_shutoff, input, 1: shutoff flag from the BERT.
REQ-012 SHALL have ports i_ber_count and i_bit_count, input, CountWidth each: live counters from the BERT.
REQ-013 SHALL have port o_bert_rst, output, 1: BERT counter clear.
REQ-014 SHALL have ports o_prbs_en, o_prbs_seed_en, o_prbs_run_en and o_ber_count_en, output, 1 each: BERT controls.
REQ-015 SHALL have ports o_busy, o_done and o_fail, output, 1 each: status.
REQ-016 SHALL have port o_state, output, 3: current state encoding.
REQ-017 SHALL have ports o_err_snap and o_bits_snap, output, CountWidth each: captured results.

Function
REQ-018 SHALL implement states IDLE=0, CLEAR=1, SEED=2, FLUSH=3, COUNT=4, SNAP=5, DONE=6.
REQ-019 IDLE SHALL go to CLEAR on i_start; o_done and o_fail SHALL clear on that same edge.
REQ-020 CLEAR SHALL assert o_bert_rst for exactly 2 cycles, then go to SEED.
REQ-021 SEED SHALL assert o_prbs_en and o_prbs_seed_en.
REQ-022 SEED SHALL count consecutive high cycles of i_prbs_seed_good; any low cycle resets the count to 0.
REQ-023 SEED SHALL go to FLUSH when the count reaches SettleCycles.
REQ-024 When i_cfg_seed_timeout is non-zero and SEED has lasted i_cfg_seed_timeout cycles without lock, SHALL set o_fail and go to DONE; lock and timeout on the same cycle SHALL resolve to lock.
REQ-025 FLUSH SHALL assert o_prbs_en and o_prbs_run_en, with o_prbs_seed_en low, for FlushCycles cycles, then go to COUNT.
REQ-026 COUNT SHALL assert o_prbs_en, o_prbs_run_en and o_ber_count_en, and go to SNAP on i_ber_shutoff or i_abort.
REQ-027 SNAP SHALL last one cycle with o_ber_count_en low, then latch i_ber_count and i_bit_count into the snap registers on the following edge and go to DONE.
REQ-028 DONE SHALL assert o_done, hold the snap registers, and go to IDLE on the cycle after entry.
REQ-029 o_done, o_fail and the snap registers SHALL hold until the next accepted i_start.
REQ-030 i_abort in CLEAR, SEED or FLUSH SHALL go directly to DONE with o_fail=1 and snap registers unchanged.
REQ-031 i_abort SHALL take priority over every other transition condition in the same cycle.
REQ-032 i_start SHALL be ignored in every state except IDLE.
REQ-033 o_busy SHALL be high in CLEAR through SNAP.
REQ-034 All outputs SHALL be registered and change one cycle after the decision edge.
REQ-035 Counters SHALL saturate and never wrap.

Reset
REQ-036 While i_rst is high on a clock edge, the state SHALL go to IDLE regardless of the current state.
REQ-037 Reset SHALL drive every output and every snap register to 0, and clear all internal counters.

Configuration
REQ-038 When macro BERT_SEQ_ERR_LIMIT_EN is defined, SHALL add input i_cfg_err_limit [CountWidth-1:0].
REQ-039 With BERT_SEQ_ERR_LIMIT_EN defined, COUNT SHALL go to SNAP when i_ber_count >= i_cfg_err_limit and i_cfg_err_limit is non-zero.
REQ-040 Without BERT_SEQ_ERR_LIMIT_EN, the port and the comparator SHALL be absent and behaviour SHALL be unchanged.

Structure
REQ-041 A shared package bert_pkg SHALL hold the state enum and the constants CLEAR_CYCLES=2 and the state width 3.
REQ-042 SHALL contain one sub-module, bert_seq_timer: a loadable saturating down-counter reused for the CLEAR, SEED-timeout and FLUSH timing.

Verification
REQ-043 i_start with seed_good high from cycle 3 -> o_prbs_seed_en high for 8 cycles, FLUSH 3 cycles, o_ber_count_en high.
REQ-044 timeout=20, seed_good held low -> o_fail=1 and o_done=1 after 20 SEED cycles, o_ber_count_en never high.
REQ-045 seed_good toggling every 5 cycles -> no lock; a following stable run of 8 cycles -> FLUSH.
REQ-046 In COUNT, i_ber_shutoff=1 with ber_count=7 and bit_count=1024 -> o_err_snap=7, o_bits_snap=1024, o_done=1.
REQ-047 i_rst asserted in COUNT -> on the next edge state=IDLE and all outputs 0; i_start in COUNT -> no effect.
REQ-048 With BERT_SEQ_ERR_LIMIT_EN and limit=5, ber_count reaching 5 -> SNAP on the next cycle, o_err_snap=5.
